// File: rtl/sqrt_iter_param.sv
// rtl/sqrt_iter_param.sv - iterative restoring integer square root, one root bit per clock
// Accepts in IDLE or DONE, iterates WIDTH/2 times in CALC, optional round-to-nearest with saturation.
module sqrt_iter_param #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               round,
    input  logic [WIDTH-1:0]   valor,
    output logic [WIDTH/2-1:0] sqrt,
    output logic [WIDTH/2:0]   resto,
    output logic               busy,
    output logic               endop
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(H + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opr;
    logic [H-1:0]     root;
    logic [H-1:0]     root_next;
    logic [H-1:0]     root_out;
    logic [H+1:0]     rem;
    logic [H+1:0]     rem_next;
    logic [H+1:0]     t;
    logic [H+1:0]     trial;
    logic [CW-1:0]    cnt;
    logic             rnd;
    logic             accept;

    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        t     = (rem << 2) | {{H{1'b0}}, opr[WIDTH-1 -: 2]};
        trial = {root, 2'b01};
        if (t >= trial) begin
            rem_next  = t - trial;
            root_next = {root[H-2:0], 1'b1};
        end else begin
            rem_next  = t;
            root_next = {root[H-2:0], 1'b0};
        end
        // Round up when the floor remainder exceeds the root, unless already all-ones.
        if (rnd && (rem_next > {2'b00, root_next}) && !(&root_next))
            root_out = root_next + H'(1);
        else
            root_out = root_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            opr   <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            rnd   <= 1'b0;
            sqrt  <= '0;
            resto <= '0;
            busy  <= 1'b0;
            endop <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    endop <= 1'b0;
                    if (accept) begin
                        opr   <= valor;
                        rnd   <= round;
                        root  <= '0;
                        rem   <= '0;
                        cnt   <= CW'(H);
                        busy  <= 1'b1;
                        state <= CALC;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CALC: begin
                    opr  <= opr << 2;
                    root <= root_next;
                    rem  <= rem_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        sqrt  <= root_out;
                        resto <= (H+1)'(rem_next);
                        busy  <= 1'b0;
                        endop <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    endop <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
